// File: rtl/distance_ascii_reporter.sv
// Multi-channel distance sampler that prints "<ch>:<digits>cm\r\n" per sample
// over a byte valid/ready stream, with per-channel near flags and overrun.
// Ports: clk, rst_n, dist_in/dist_valid (samples), tx_data/tx_valid/tx_ready
// (byte stream), near, overrun, overrun_clr, busy.
module distance_ascii_reporter #(
  parameter int NUM_CH         = 2,
  parameter int DIST_W         = 16,
  parameter int NUM_DIGITS     = 5,
  parameter int SUPPRESS_ZEROS = 1,
  parameter int NEAR_CM        = 20,
  parameter int FAR_CM         = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DIST_W-1:0] dist_in,
  input  logic [NUM_CH-1:0]        dist_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [NUM_CH-1:0]        near,
  output logic [NUM_CH-1:0]        overrun,
  input  logic                     overrun_clr,
  output logic                     busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DIST_W + 1);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [63:0] max_val(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0]       MAX_V  = max_val(NUM_DIGITS);
  localparam logic [DIST_W-1:0] NEAR_V = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] FAR_V  = DIST_W'(FAR_CM);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CONV, S_ID, S_COLON,
    S_DIG, S_C, S_M, S_CR, S_LF
  } state_t;

  state_t              state, state_nx;
  logic [DIST_W-1:0]   sample_q [NUM_CH];
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   load_clr;
  logic [CH_W-1:0]     ch, grant;
  logic                any_pend;
  logic [DIST_W-1:0]   bin;
  logic [BCD_W-1:0]    bcd, bcd_adj;
  logic                sat;
  logic [CNT_W-1:0]    cnt;
  logic [DIG_W-1:0]    dig_idx, first_idx;
  logic [3:0]          cur_dig;

  assign any_pend = |pending;
  assign busy     = (state != S_IDLE);

  // Round-robin: search starts one past the last served channel.
  always_comb begin
    int   c;
    logic found;
    grant = ch;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = int'(ch) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && pending[c[CH_W-1:0]]) begin
        found = 1'b1;
        grant = CH_W'(c);
      end
    end
  end

  always_comb begin
    load_clr = '0;
    if (state == S_LOAD) load_clr[ch] = 1'b1;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  // First printed digit: highest nonzero one, or the last digit.
  always_comb begin
    first_idx = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (bcd[4*d +: 4] != 4'd0) first_idx = DIG_W'(d);
    if (sat || SUPPRESS_ZEROS == 0)
      first_idx = DIG_W'(NUM_DIGITS - 1);
  end

  always_comb begin
    cur_dig = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (DIG_W'(d) == dig_idx) cur_dig = bcd[4*d +: 4];
    if (sat) cur_dig = 4'd9;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state)
      S_IDLE:  if (any_pend) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_CONV;
      S_CONV:  if (cnt == CNT_W'(DIST_W - 1)) state_nx = S_ID;
      S_ID: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + 8'(ch);
        if (tx_ready) state_nx = S_COLON;
      end
      S_COLON: begin
        tx_valid = 1'b1;
        tx_data  = 8'h3A;
        if (tx_ready) state_nx = S_DIG;
      end
      S_DIG: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, cur_dig};
        if (tx_ready && dig_idx == '0) state_nx = S_C;
      end
      S_C: begin
        tx_valid = 1'b1;
        tx_data  = 8'h63;
        if (tx_ready) state_nx = S_M;
      end
      S_M: begin
        tx_valid = 1'b1;
        tx_data  = 8'h6D;
        if (tx_ready) state_nx = S_CR;
      end
      S_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_nx = S_LF;
      end
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ch      <= CH_W'(NUM_CH - 1);
      bin     <= '0;
      bcd     <= '0;
      sat     <= 1'b0;
      cnt     <= '0;
      dig_idx <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:  if (any_pend) ch <= grant;
        S_LOAD: begin
          bin <= sample_q[ch];
          bcd <= '0;
          sat <= 64'(sample_q[ch]) > MAX_V;
          cnt <= '0;
        end
        S_CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], bin[DIST_W-1]};
          bin <= bin << 1;
          cnt <= cnt + CNT_W'(1);
        end
        S_COLON: if (tx_ready) dig_idx <= first_idx;
        S_DIG:
          if (tx_ready && dig_idx != '0)
            dig_idx <= dig_idx - DIG_W'(1);
        default: ;
      endcase
    end
  end

  // Capture side; a capture coinciding with LOAD of the same channel
  // re-arms pending without counting as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      near    <= '0;
      for (int k = 0; k < NUM_CH; k++) sample_q[k] <= '0;
    end else begin
      pending <= (pending & ~load_clr) | dist_valid;
      overrun <= (overrun & {NUM_CH{~overrun_clr}})
               | (dist_valid & pending & ~load_clr);
      for (int k = 0; k < NUM_CH; k++) begin
        if (dist_valid[k]) begin
          sample_q[k] <= dist_in[k*DIST_W +: DIST_W];
          if (dist_in[k*DIST_W +: DIST_W] <= NEAR_V)
            near[k] <= 1'b1;
          else if (dist_in[k*DIST_W +: DIST_W] >= FAR_V)
            near[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/distance_ascii_reporter.md
Name: distance_ascii_reporter

Overview:
- Multi-channel successor to the single-sensor distance printer.
- Latches distance samples from NUM_CH ranging sensors and converts each to BCD with a sequential double-dabble converter.
- Emits one ASCII line per sample, formatted `<ch>:<digits>cm\r\n`, over a byte valid/ready stream that feeds the UART transmitter.
- Also maintains a per-channel proximity flag with hysteresis.

Parameters:
- NUM_CH, 2: number of sensor channels (1..10; the channel ID prints as a single digit).
- DIST_W, 16: width of each distance sample in cm.
- NUM_DIGITS, 5: decimal digit field width (1..5).
- SUPPRESS_ZEROS, 1: 1 = drop leading zeros; the last digit is always sent.
- NEAR_CM, 20: near flag sets when sample <= NEAR_CM.
- FAR_CM, 25: near flag clears when sample >= FAR_CM. FAR_CM must be greater than NEAR_CM.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- dist_in, in, NUM_CH*DIST_W: packed samples; channel k occupies bits [k*DIST_W +: DIST_W].
- dist_valid, in, NUM_CH: one-cycle strobe per channel; dist_in is sampled on the same edge.
- tx_data, out, 8: ASCII byte.
- tx_valid, out, 1: tx_data is valid.
- tx_ready, in, 1: sink accepts the byte.
- near, out, NUM_CH: proximity flags.
- overrun, out, NUM_CH: sticky; sample overwritten before it was printed.
- overrun_clr, in, 1: clears all overrun bits.
- busy, out, 1: state is not IDLE.

Behaviour:
- Reset is asynchronous active-low. On reset:
  - tx_valid=0, tx_data=0, near=0, overrun=0, busy=0.
  - All pending bits clear; state=IDLE.
  - A reset asserted mid-line abandons the line; no partial byte completes afterwards.
- Capture:
  - dist_valid[k] loads sample register k and sets pending[k].
  - If pending[k] is already set, the sample is overwritten and overrun[k] is set.
  - Capture runs independently of the FSM, including for the channel currently printing. That channel's value was already copied at LOAD.
  - overrun_clr clears overrun. If it coincides with a new overrun event, set wins.
- Proximity, per channel, on each dist_valid[k]:
  - value <= NEAR_CM: near[k] <= 1.
  - value >= FAR_CM: near[k] <= 0.
  - Otherwise near[k] holds.
- Arbitration:
  - Round-robin starting after the last served channel; channel 0 has first priority after reset.
  - Evaluated only in IDLE.
- FSM:
  - IDLE: if any pending bit is set, go to LOAD.
  - LOAD: copy the selected sample into the working register; clear its pending bit (a same-cycle capture re-sets it without overrun); record the channel.
  - CONV: exactly DIST_W cycles of shift-and-add-3 into a 4*NUM_DIGITS-bit BCD register.
    - If the sample exceeds 10^NUM_DIGITS-1, the result saturates to all 9s.
  - SEND_ID: '0'+ch.
  - SEND_COLON: 0x3A.
  - SEND_DIG: iterate from the most significant digit down.
    - With SUPPRESS_ZEROS=1, leading zero digits are skipped without spending a cycle on a byte, except the last digit.
  - SEND_C 0x63, SEND_M 0x6D, SEND_CR 0x0D, SEND_LF 0x0A, then IDLE.
- Handshake:
  - In each SEND state, tx_valid=1 and tx_data is stable until the cycle in which tx_valid and tx_ready are both high.
  - The next byte is presented on the following cycle, so maximum throughput is one byte per cycle.
  - tx_valid never drops without a transfer, except on reset.
- Latency:
  - With the FSM in IDLE and nothing pending, dist_valid at edge 0 gives tx_valid=1 with the ID byte after edge DIST_W+2.
  - Back-to-back lines have LF-accept, IDLE, LOAD, then DIST_W CONV cycles between them.
- Arithmetic:
  - BCD digits are 4 bits each.
  - ASCII digit = 0x30 + digit.
  - Channel ID = 0x30 + channel index.
- busy=0 only in IDLE.

Test Plan:
1. NUM_CH=2, DIST_W=16, NUM_DIGITS=5. ch0=123, tx_ready=1 → bytes 30 3A 31 32 33 63 6D 0D 0A. First tx_valid 18 cycles after the strobe; one byte per cycle.
2. ch1=0 → 31 3A 30 63 6D 0D 0A. Then, with SUPPRESS_ZEROS=0, ch1=7 → 31 3A 30 30 30 30 37 63 6D 0D 0A.
3. Both channels strobe in the same cycle, ch0=40, ch1=65535 → ch0 line first, then 31 3A 36 35 35 33 35 63 6D 0D 0A. No overrun.
4. tx_ready toggled randomly or held low 50 cycles mid-line → byte sequence unchanged; tx_data stable while tx_valid=1 and tx_ready=0.
5. Hysteresis on ch0 with sequence 30,20,22,24,25,19 → near[0] = 0,1,1,1,0,1.
6. NUM_DIGITS=3 with value 1234 → digits 39 39 39. Three ch0 strobes during one CONV → overrun[0]=1 and only the last value is printed next; overrun_clr → overrun[0]=0. Reset mid-SEND_DIG → tx_valid=0 immediately; next line is well-formed.
